bfp_out_packer: RTL and testbench

- Sits directly downstream of the BFP compute kernel; consumes its serial stream of 8-bit output components, one transaction per output channel.
- Packs pc consecutive components of the same output pixel into one pc*data_width word, ready for the output buffer / writeback.
- Tracks channel position within each pixel, zero-pads and flags the final partial word, and marks the pixel end.
- Double-buffered (assembly + output register) so the kernel is not stalled while a finished word waits for dn_rdy.

---
 rtl/bfp_out_packer.sv | 148 ++++++++++++++
 tb/tb_bfp_out_packer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bfp_out_packer.sv
// Packs the BFP kernel's serial component stream into pc-lane words, one pixel at a time.
// The assembly stage can hold a finished word while the output register waits on dn_rdy.

module bfp_out_lane #(
  parameter int data_width = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [data_width-1:0] wr_dat,
  input  logic                  a_clr,
  input  logic                  ld_dir,
  input  logic                  ld_hold,
  output logic [data_width-1:0] o_dat,
  output logic                  o_keep
);
  logic [data_width-1:0] a_dat;
  logic                  a_keep;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_dat  <= '0;
      a_keep <= 1'b0;
      o_dat  <= '0;
      o_keep <= 1'b0;
    end else begin
      // Direct load merges the completing beat, which has not reached assembly yet.
      if (ld_dir) begin
        o_dat  <= wr_en ? wr_dat : a_dat;
        o_keep <= wr_en | a_keep;
      end else if (ld_hold) begin
        o_dat  <= a_dat;
        o_keep <= a_keep;
      end
      if (a_clr) begin
        a_dat  <= '0;
        a_keep <= 1'b0;
      end else if (wr_en) begin
        a_dat  <= wr_dat;
        a_keep <= 1'b1;
      end
    end
  end
endmodule

module bfp_out_packer #(
  parameter int pc           = 64,
  parameter int data_width   = 8,
  parameter int ch_cnt_width = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ch_cnt_width-1:0]    cfg_num_ch,
  input  logic                       up_vld,
  input  logic [data_width-1:0]      up_dat,
  output logic                       up_rdy,
  output logic                       dn_vld,
  output logic [pc*data_width-1:0]   dn_dat,
  output logic [pc-1:0]              dn_keep,
  output logic                       dn_last,
  input  logic                       dn_rdy,
  output logic                       pixel_done,
  output logic                       cfg_err
);
  localparam int LW = $clog2(pc);

  logic [LW-1:0]           lane_idx;
  logic [ch_cnt_width-1:0] ch_idx, num_ch, eff_num;
  logic                    a_full, a_last;
  logic                    acc, first, is_last, complete;
  logic                    dn_fire, o_free, ld_dir, ld_hold, a_clr;
  logic [pc-1:0][data_width-1:0] dat_arr;
  logic [pc-1:0]           keep_arr;

  assign acc      = up_vld && up_rdy;
  assign first    = (ch_idx == '0);
  assign eff_num  = !first ? num_ch :
                    (cfg_num_ch == '0) ? ch_cnt_width'(1) : cfg_num_ch;
  assign is_last  = (ch_idx == eff_num - 1'b1);
  assign complete = acc && ((lane_idx == LW'(pc - 1)) || is_last);
  assign dn_fire  = dn_vld && dn_rdy;
  assign o_free   = !dn_vld || dn_rdy;
  assign ld_dir   = complete && o_free;
  assign ld_hold  = a_full && dn_fire;
  assign a_clr    = ld_dir || ld_hold;

  genvar i;
  generate
    for (i = 0; i < pc; i++) begin : g_lane
      bfp_out_lane #(.data_width(data_width)) u_lane (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (acc && (lane_idx == LW'(i))),
        .wr_dat (up_dat),
        .a_clr  (a_clr),
        .ld_dir (ld_dir),
        .ld_hold(ld_hold),
        .o_dat  (dat_arr[i]),
        .o_keep (keep_arr[i])
      );
    end
  endgenerate

  assign dn_dat  = dat_arr;
  assign dn_keep = keep_arr;

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_idx   <= '0;
      ch_idx     <= '0;
      num_ch     <= '0;
      a_full     <= 1'b0;
      a_last     <= 1'b0;
      up_rdy     <= 1'b0;
      dn_vld     <= 1'b0;
      dn_last    <= 1'b0;
      pixel_done <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      pixel_done <= dn_fire && dn_last;
      if (acc) begin
        if (first) begin
          num_ch <= eff_num;
          if (cfg_num_ch == '0) cfg_err <= 1'b1;
        end
        ch_idx   <= is_last ? '0 : ch_idx + 1'b1;
        lane_idx <= complete ? '0 : lane_idx + 1'b1;
      end
      if (ld_dir) begin
        dn_vld  <= 1'b1;
        dn_last <= is_last;
      end else if (ld_hold) begin
        dn_vld  <= 1'b1;
        dn_last <= a_last;
      end else if (dn_fire) begin
        dn_vld  <= 1'b0;
      end
      if (complete && !o_free) begin
        a_full <= 1'b1;
        a_last <= is_last;
      end else if (ld_hold) begin
        a_full <= 1'b0;
      end
      // Stall upstream for as long as a finished word sits in assembly.
      up_rdy <= !((a_full && !dn_fire) || (complete && !o_free));
    end
  end
endmodule

// File: tb/tb_bfp_out_packer.sv
// Bench for bfp_out_packer (pc=4): directed steps plus random pixels against a word-level model.

module tb_bfp_out_packer;
  localparam int PC = 4;
  localparam int DW = 8;
  localparam int CW = 12;

  typedef struct {
    logic [PC*DW-1:0] dat;
    logic [PC-1:0]    keep;
    logic             last;
  } word_t;

  logic              clk, rst;
  logic [CW-1:0]     cfg_num_ch;
  logic              up_vld, up_rdy;
  logic [DW-1:0]     up_dat;
  logic              dn_vld, dn_rdy, dn_last, pixel_done, cfg_err;
  logic [PC*DW-1:0]  dn_dat;
  logic [PC-1:0]     dn_keep;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int rdy_mode = 0;
  int c0;
  word_t exp_q[$];
  logic [7:0] pix_vals[$];

  bit prev_last = 0;
  bit held = 0;
  logic [PC*DW-1:0] h_dat;
  logic [PC-1:0] h_keep;
  logic h_last;
  word_t me;

  bfp_out_packer #(.pc(PC), .data_width(DW), .ch_cnt_width(CW)) dut (
    .clk(clk), .rst(rst), .cfg_num_ch(cfg_num_ch),
    .up_vld(up_vld), .up_dat(up_dat), .up_rdy(up_rdy),
    .dn_vld(dn_vld), .dn_dat(dn_dat), .dn_keep(dn_keep), .dn_last(dn_last),
    .dn_rdy(dn_rdy), .pixel_done(pixel_done), .cfg_err(cfg_err)
  );

  initial begin clk = 0; forever #5 clk = ~clk; end
  initial forever begin @(posedge clk); cyc++; end

  initial begin
    dn_rdy = 0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: dn_rdy = 0;
        1: dn_rdy = 1;
        default: dn_rdy = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected words for the pixel held in pix_vals, from lane/channel arithmetic.
  task automatic model_pixel(input int n);
    word_t e;
    for (int w = 0; w * PC < n; w++) begin
      e.dat = '0;
      e.keep = '0;
      for (int j = 0; j < PC; j++)
        if (w * PC + j < n) begin
          e.dat[j*DW +: DW] = pix_vals[w*PC + j];
          e.keep[j] = 1'b1;
        end
      e.last = ((w + 1) * PC >= n);
      exp_q.push_back(e);
    end
  endtask

  task automatic new_pixel(input int n, input logic [7:0] base, input bit rnd, input bit mdl);
    pix_vals.delete();
    for (int i = 0; i < n; i++) pix_vals.push_back(rnd ? 8'($urandom) : 8'(int'(base) + i));
    if (mdl) model_pixel(n);
  endtask

  task automatic sync();
    @(posedge clk); #1;
  endtask

  // Must be entered just after a rising edge.
  task automatic send_beat(input logic [7:0] v);
    up_vld = 1; up_dat = v;
    @(negedge clk);
    for (int t = 0; t < 200 && up_rdy !== 1'b1; t++) @(negedge clk);
    if (up_rdy !== 1'b1) chk("up_rdy_timeout", {63'b0, up_rdy}, 64'd1);
    @(posedge clk); #1;
    up_vld = 0;
  endtask

  task automatic stream(input int cfg, input int first, input int cnt, input bit gaps);
    for (int i = first; i < first + cnt; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) sync();
      if (i == 0) cfg_num_ch = CW'(cfg);
      send_beat(pix_vals[i]);
      if (i == 0) cfg_num_ch = CW'($urandom);
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 500 && exp_q.size() != 0; t++) @(negedge clk);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  // Output monitor: word order/content, hold stability, pixel_done timing.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      prev_last = 0; held = 0;
    end else begin
      chk("pixel_done", {63'b0, pixel_done}, {63'b0, prev_last});
      if (held) chk("hold_stable", {dn_vld, dn_last, dn_keep, dn_dat}, {1'b1, h_last, h_keep, h_dat});
      if (dn_vld && dn_rdy) begin
        if (exp_q.size() == 0) chk("spurious_word", {63'b0, dn_vld}, 64'd0);
        else begin
          me = exp_q.pop_front();
          chk("word_dat", 64'(dn_dat), 64'(me.dat));
          chk("word_keep", 64'(dn_keep), 64'(me.keep));
          chk("word_last", {63'b0, dn_last}, {63'b0, me.last});
        end
      end
      prev_last = dn_vld && dn_rdy && dn_last;
      held = dn_vld && !dn_rdy;
      h_dat = dn_dat; h_keep = dn_keep; h_last = dn_last;
    end
  end

  initial begin
    rst = 1; up_vld = 0; up_dat = 0; cfg_num_ch = 0;
    repeat (2) @(posedge clk); #1;
    @(negedge clk);
    chk("rst_up_rdy", {63'b0, up_rdy}, 64'd0);
    chk("rst_dn_vld", {63'b0, dn_vld}, 64'd0);
    chk("rst_dn_dat", 64'(dn_dat), 64'd0);
    chk("rst_dn_keep", 64'(dn_keep), 64'd0);
    chk("rst_dn_last", {63'b0, dn_last}, 64'd0);
    chk("rst_cfg_err", {63'b0, cfg_err}, 64'd0);
    sync(); rst = 0;
    @(negedge clk); chk("rdy_reset_cycle", {63'b0, up_rdy}, 64'd0);
    @(negedge clk); chk("rdy_after_reset", {63'b0, up_rdy}, 64'd1);

    // 8 channels, values 1..8
    rdy_mode = 1; sync();
    new_pixel(8, 8'd1, 0, 1);
    stream(8, 0, 4, 0);
    @(negedge clk);
    chk("p8_w1_vld", {63'b0, dn_vld}, 64'd1);
    chk("p8_w1_dat", 64'(dn_dat), 64'h04030201);
    chk("p8_w1_keep", 64'(dn_keep), 64'hf);
    chk("p8_w1_last", {63'b0, dn_last}, 64'd0);
    sync(); c0 = cyc;
    stream(8, 4, 4, 0);
    chk("p8_thruput", 64'(cyc - c0), 64'd4);
    @(negedge clk);
    chk("p8_w2_dat", 64'(dn_dat), 64'h08070605);
    chk("p8_w2_last", {63'b0, dn_last}, 64'd1);
    @(negedge clk); chk("p8_pixel_done", {63'b0, pixel_done}, 64'd1);

    // 6 channels: padded partial word, then next pixel from lane 0
    sync(); new_pixel(6, 8'hA0, 0, 1); stream(6, 0, 6, 0);
    @(negedge clk);
    chk("p6_w2_dat", 64'(dn_dat), 64'h0000A5A4);
    chk("p6_w2_keep", 64'(dn_keep), 64'h3);
    chk("p6_w2_last", {63'b0, dn_last}, 64'd1);
    sync(); new_pixel(4, 8'hB0, 0, 1); stream(4, 0, 4, 0);
    @(negedge clk);
    chk("p4_dat", 64'(dn_dat), 64'hB3B2B1B0);
    chk("p4_keep", 64'(dn_keep), 64'hf);
    drain();

    // 12 channels with downstream stalled
    rdy_mode = 0; sync();
    new_pixel(12, 8'h10, 0, 1);
    stream(12, 0, 8, 0);
    @(negedge clk);
    chk("stall_up_rdy", {63'b0, up_rdy}, 64'd0);
    chk("stall_dn_dat", 64'(dn_dat), 64'h13121110);
    repeat (3) @(negedge clk);
    chk("stall_up_rdy_hold", {63'b0, up_rdy}, 64'd0);
    rdy_mode = 1;
    @(posedge clk); #2;
    @(negedge clk);
    chk("release_rdy_lo", {63'b0, up_rdy}, 64'd0);
    chk("release_w1", 64'(dn_dat), 64'h13121110);
    @(negedge clk);
    chk("release_rdy_hi", {63'b0, up_rdy}, 64'd1);
    chk("release_w2", 64'(dn_dat), 64'h17161514);
    sync(); stream(12, 8, 4, 0);
    drain();

    // cfg_num_ch == 0
    sync(); new_pixel(1, 8'h55, 0, 1); stream(0, 0, 1, 0);
    @(negedge clk);
    chk("cfg0_dat", 64'(dn_dat), 64'h55);
    chk("cfg0_keep", 64'(dn_keep), 64'h1);
    chk("cfg0_last", {63'b0, dn_last}, 64'd1);
    chk("cfg0_err", {63'b0, cfg_err}, 64'd1);

    // single-channel pixels back to back
    sync(); c0 = cyc;
    for (int k = 0; k < 6; k++) begin
      new_pixel(1, 8'(8'h60 + k), 0, 1);
      stream(1, 0, 1, 0);
    end
    chk("nc1_thruput", 64'(cyc - c0), 64'd6);
    @(negedge clk); chk("nc1_pixel_done", {63'b0, pixel_done}, 64'd1);
    drain();

    // random pixels, random gaps and backpressure
    rdy_mode = 2; sync();
    repeat (25) begin
      int n;
      n = $urandom_range(1, 11);
      new_pixel(n, 8'h00, 1, 1);
      stream(n, 0, n, 1);
    end
    rdy_mode = 1;
    drain();
    chk("cfg_err_sticky", {63'b0, cfg_err}, 64'd1);

    // reset in the middle of a word
    sync();
    new_pixel(4, 8'hC0, 0, 0);
    stream(4, 0, 3, 0);
    rst = 1; sync(); rst = 0;
    @(negedge clk);
    chk("mrst_up_rdy", {63'b0, up_rdy}, 64'd0);
    chk("mrst_dn_vld", {63'b0, dn_vld}, 64'd0);
    chk("mrst_dn_dat", 64'(dn_dat), 64'd0);
    chk("mrst_dn_keep", 64'(dn_keep), 64'd0);
    chk("mrst_cfg_err", {63'b0, cfg_err}, 64'd0);
    sync();
    new_pixel(4, 8'hD0, 0, 1); stream(4, 0, 4, 0);
    @(negedge clk);
    chk("mrst_next_dat", 64'(dn_dat), 64'hD3D2D1D0);
    chk("mrst_next_keep", 64'(dn_keep), 64'hf);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
